// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of independent wrap/saturate up/down counters (COUNTER_BANK_SATURATE_EN selects saturation)
module counter_bank #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 3,
    parameter int MAX_VALUE   = 7,
    parameter int INIT_VALUE  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             i__inc,
    input  logic [NUM_CH-1:0]             i__dec,
    input  logic [NUM_CH-1:0]             i__clear,
    input  logic [NUM_CH-1:0]             i__load,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] i__load_value,
    output logic [NUM_CH*COUNT_WIDTH-1:0] o__count,
    output logic [NUM_CH*COUNT_WIDTH-1:0] o__count__next,
    output logic [NUM_CH-1:0]             o__ovf,
    output logic [NUM_CH-1:0]             o__udf,
    output logic [NUM_CH-1:0]             o__at_max,
    output logic [NUM_CH-1:0]             o__at_zero
);

`ifdef COUNTER_BANK_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    localparam logic [COUNT_WIDTH-1:0] MAX_C  = COUNT_WIDTH'(MAX_VALUE);
    localparam logic [COUNT_WIDTH-1:0] INIT_C = COUNT_WIDTH'(INIT_VALUE);
    localparam logic [COUNT_WIDTH-1:0] ZERO_C = '0;
    localparam logic [COUNT_WIDTH-1:0] ONE_C  = COUNT_WIDTH'(1);

    generate
        if (NUM_CH < 1 || COUNT_WIDTH < 1) begin : g_bad_size
            $error("counter_bank: NUM_CH and COUNT_WIDTH must be >= 1");
        end
        if (MAX_VALUE <= 0 || MAX_VALUE > (2 ** COUNT_WIDTH) - 1) begin : g_bad_max
            $error("counter_bank: MAX_VALUE out of range for COUNT_WIDTH");
        end
        if (INIT_VALUE < 0 || INIT_VALUE > MAX_VALUE) begin : g_bad_init
            $error("counter_bank: INIT_VALUE must lie in 0..MAX_VALUE");
        end
    endgenerate

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [COUNT_WIDTH-1:0] count_q;
        logic [COUNT_WIDTH-1:0] count_d;
        logic [COUNT_WIDTH-1:0] load_v;
        logic                   ovf_q, udf_q, ovf_d, udf_d;

        assign load_v = i__load_value[c*COUNT_WIDTH +: COUNT_WIDTH];

        // Reset is folded in here so o__count__next always predicts o__count.
        always_comb begin
            count_d = count_q;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            if (reset) begin
                count_d = INIT_C;
            end else if (i__clear[c]) begin
                count_d = ZERO_C;
            end else if (i__load[c]) begin
                count_d = (load_v > MAX_C) ? MAX_C : load_v;
            end else if (i__inc[c] && !i__dec[c]) begin
                if (count_q == MAX_C) begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? MAX_C : ZERO_C;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else if (i__dec[c] && !i__inc[c]) begin
                if (count_q == ZERO_C) begin
                    udf_d   = 1'b1;
                    count_d = SATURATE ? ZERO_C : MAX_C;
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                count_q <= INIT_C;
                ovf_q   <= 1'b0;
                udf_q   <= 1'b0;
            end else begin
                count_q <= count_d;
                ovf_q   <= ovf_d;
                udf_q   <= udf_d;
            end
        end

        assign o__count[c*COUNT_WIDTH +: COUNT_WIDTH]       = count_q;
        assign o__count__next[c*COUNT_WIDTH +: COUNT_WIDTH] = count_d;
        assign o__ovf[c]     = ovf_q;
        assign o__udf[c]     = udf_q;
        assign o__at_max[c]  = (count_q == MAX_C);
        assign o__at_zero[c] = (count_q == ZERO_C);
    end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - scoreboard bench for counter_bank against an arithmetic reference model
module tb_counter_bank;
    localparam int N    = 2;
    localparam int W    = 3;
    localparam int MAXV = 5;
    localparam int INIT = 0;
`ifdef COUNTER_BANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [N*W-1:0] cnt;
        logic [N-1:0]   ovf;
        logic [N-1:0]   udf;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   i__inc = '0, i__dec = '0, i__clear = '0, i__load = '0;
    logic [N*W-1:0] i__load_value = '0;
    logic [N*W-1:0] o__count, o__count__next;
    logic [N-1:0]   o__ovf, o__udf, o__at_max, o__at_zero;

    int   checks = 0;
    int   failures = 0;
    int   model_cnt [N];
    exp_t q_reg [$];
    logic [N*W-1:0] q_comb [$];

    counter_bank #(.NUM_CH(N), .COUNT_WIDTH(W), .MAX_VALUE(MAXV), .INIT_VALUE(INIT)) dut (
        .clk(clk), .reset(reset),
        .i__inc(i__inc), .i__dec(i__dec), .i__clear(i__clear), .i__load(i__load),
        .i__load_value(i__load_value),
        .o__count(o__count), .o__count__next(o__count__next),
        .o__ovf(o__ovf), .o__udf(o__udf), .o__at_max(o__at_max), .o__at_zero(o__at_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input logic [N-1:0] inc, input logic [N-1:0] dec,
                        input logic [N-1:0] clr, input logic [N-1:0] ld, input logic [N*W-1:0] lv);
        exp_t e;
        int   v, n, lvc;
        @(negedge clk);
        reset = rst; i__inc = inc; i__dec = dec; i__clear = clr; i__load = ld; i__load_value = lv;
        e = '0;
        for (int c = 0; c < N; c++) begin
            v   = model_cnt[c];
            lvc = int'(lv[c*W +: W]);
            n   = v;
            if (rst) n = INIT;
            else if (clr[c]) n = 0;
            else if (ld[c]) n = (lvc > MAXV) ? MAXV : lvc;
            else if (inc[c] && !dec[c]) begin
                e.ovf[c] = (v == MAXV);
                n = SAT ? ((v + 1 > MAXV) ? MAXV : v + 1) : (v + 1) % (MAXV + 1);
            end else if (dec[c] && !inc[c]) begin
                e.udf[c] = (v == 0);
                n = SAT ? ((v == 0) ? 0 : v - 1) : (v + MAXV) % (MAXV + 1);
            end
            model_cnt[c] = n;
            e.cnt[c*W +: W] = W'(n);
        end
        q_comb.push_back(e.cnt);
        q_reg.push_back(e);
    endtask

    always begin
        @(negedge clk);
        #2;
        if (q_comb.size() > 0) check("count_next", 32'(o__count__next), 32'(q_comb.pop_front()));
    end

    always begin
        exp_t e;
        logic [N-1:0] am, az;
        @(posedge clk);
        #1;
        if (q_reg.size() > 0) begin
            e = q_reg.pop_front();
            for (int c = 0; c < N; c++) begin
                am[c] = (int'(e.cnt[c*W +: W]) == MAXV);
                az[c] = (int'(e.cnt[c*W +: W]) == 0);
            end
            check("count", 32'(o__count), 32'(e.cnt));
            check("ovf", 32'(o__ovf), 32'(e.ovf));
            check("udf", 32'(o__udf), 32'(e.udf));
            check("at_max", 32'(o__at_max), 32'(am));
            check("at_zero", 32'(o__at_zero), 32'(az));
        end
    end

    initial begin
        for (int c = 0; c < N; c++) model_cnt[c] = INIT;
        step(1, 0, 0, 0, 0, 0);
        step(1, 2'b11, 2'b00, 0, 0, 0);
        repeat (6) step(0, 2'b01, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 2'b10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 2'b01, 0, 0, 2'b01, 6'b000_111);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 2'b01, 0, 0);
        repeat (3) step(0, 2'b01, 0, 0, 0, 0);
        step(0, 2'b01, 0, 2'b01, 2'b01, 6'b000_010);
        repeat (3) step(0, 2'b01, 0, 0, 0, 0);
        step(0, 2'b01, 2'b01, 0, 0, 0);
        repeat (2) step(0, 2'b01, 0, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10000; i++) begin
            logic [N-1:0] clr, ld;
            for (int c = 0; c < N; c++) begin
                clr[c] = ($urandom_range(0, 15) == 0);
                ld[c]  = ($urandom_range(0, 7) == 0);
            end
            step($urandom_range(0, 127) == 0, N'($urandom), N'($urandom), clr, ld, (N*W)'($urandom));
        end
        step(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("queues_drained", 32'(q_reg.size() + q_comb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
